// File: rtl/d_ff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready at both ends, freeze (en), flush (clr) and occupancy count.
// Latency: DEPTH cycles from accept to presentation when unblocked; bubbles collapse, 1 beat/cycle sustained.
// Backpressure: out_ready low stalls the last stage; in_ready = en & ~clr & (a free slot or out_ready), comb from out_ready.
// Optional: define D_FF_PIPE_PARITY_EN to add per-stage even parity, err_inj and par_err.
module d_ff_pipe #(
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_q,
`ifdef D_FF_PIPE_PARITY_EN
  input  logic          err_inj,
  output logic          par_err,
`endif
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic [N-1:0]     dat [DEPTH];
  logic [N-1:0]     src [DEPTH];
  logic             go;
  logic             hole;
  logic             acc;
  logic             xfer;

  // Advance chain: a valid stage moves when the output transfers or any later stage is empty.
  always_comb begin
    go   = en & ~clr;
    hole = out_ready;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = go & vld[k] & hole;
      hole   = hole | ~vld[k];
    end
    in_ready = go & hole;
    acc      = in_valid & in_ready;
    xfer     = adv[DEPTH-1];
  end

  // Load sources: stage 0 takes the accepted input, every other stage takes its predecessor.
  always_comb begin
    ld     = '0;
    ld[0]  = acc;
    src[0] = in_d;
    for (int k = 1; k < DEPTH; k++) begin
      ld[k]  = adv[k-1];
      src[k] = dat[k-1];
    end
  end

  // Stage registers and occupancy; clr wins over en, en=0 freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else if (clr) begin
      vld   <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          vld[k] <= 1'b1;
          dat[k] <= src[k];
        end else if (adv[k]) begin
          vld[k] <= 1'b0;
        end
      end
      count <= count + CW'(acc) - CW'(xfer);
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_q     = dat[DEPTH-1];

`ifdef D_FF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
  logic [DEPTH-1:0] psrc;

  // Parity source: computed (and optionally corrupted) at accept, then carried with the data.
  always_comb begin
    psrc    = '0;
    psrc[0] = (^in_d) ^ err_inj;
    for (int k = 1; k < DEPTH; k++) psrc[k] = par[k-1];
  end

  // Parity bits move exactly like the data they protect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par <= '0;
    end else if (clr) begin
      par <= '0;
    end else if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) par[k] <= psrc[k];
      end
    end
  end

  assign par_err = out_valid & ((^out_q) != par[DEPTH-1]);
`endif

endmodule
